axi4_lite_cmd_sequencer: RTL and testbench

Command-queue front end sitting directly upstream of the AXI4-Lite master's internal request interface (addr/write/wdata/transfer/ready/rdata).
- Accepts read/write commands from a producer through a valid/ready port and buffers them in a command FIFO.
- Issues the commands to the master one at a time and waits for each to complete.
- Returns read data through a valid/ready response FIFO.
- Replaces hand-sequenced transfer pulses with a back-pressured stream.

---
 rtl/axi4_lite_cmd_sequencer.sv | 161 ++++++++++++++++
 tb/tb_axi4_lite_cmd_sequencer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_cmd_sequencer.sv
// Command-queue front end for the AXI4-Lite master request port: buffers producer
// commands, issues them one at a time, and streams read data back through a FIFO.

module axi4_lite_cmd_sequencer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             data_i,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

    assign data_o  = mem_q[rptr_q[AW-1:0]];
    assign count_o = wptr_q - rptr_q;
endmodule

module axi4_lite_cmd_sequencer #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic [DATA_W-1:0]            cmd_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic [ADDR_W-1:0]            addr,
    output logic                         write,
    output logic [DATA_W-1:0]            wdata,
    output logic                         transfer,
    input  logic                         ready,
    input  logic [DATA_W-1:0]            rdata,
    output logic                         busy,
    output logic [$clog2(CMD_DEPTH):0]   cmd_count
);
    localparam int CW = $clog2(CMD_DEPTH) + 1;
    localparam int RW = $clog2(RSP_DEPTH) + 1;
    localparam int FW = 1 + ADDR_W + DATA_W;
    localparam logic [CW-1:0] CMD_FULL = CW'(CMD_DEPTH);
    localparam logic [RW-1:0] RSP_FULL = RW'(RSP_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              transfer_q, transfer_d;

    logic          cmd_push, cmd_pop, cmd_empty;
    logic [FW-1:0] cmd_head;
    logic          rsp_push, rsp_pop;
    logic [RW-1:0] rsp_count;

    assign cmd_ready = (cmd_count != CMD_FULL);
    assign cmd_empty = (cmd_count == '0);
    assign cmd_push  = cmd_valid && cmd_ready;

    assign rsp_valid = (rsp_count != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_push  = (state_q == WAIT) && ready && !write_q;

    axi4_lite_cmd_sequencer_fifo #(.W(FW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk_i   (ACLK),
        .rst_ni  (ARESETn),
        .push_i  (cmd_push),
        .pop_i   (cmd_pop),
        .data_i  ({cmd_write, cmd_addr, cmd_wdata}),
        .data_o  (cmd_head),
        .count_o (cmd_count)
    );

    axi4_lite_cmd_sequencer_fifo #(.W(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk_i   (ACLK),
        .rst_ni  (ARESETn),
        .push_i  (rsp_push),
        .pop_i   (rsp_pop),
        .data_i  (rdata),
        .data_o  (rsp_rdata),
        .count_o (rsp_count)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            transfer_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            transfer_q <= transfer_d;
        end
    end

    // A read is only launched when its response is guaranteed a slot.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        transfer_d = 1'b0;
        cmd_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cmd_empty && (cmd_head[FW-1] || rsp_count < RSP_FULL)) begin
                    state_d    = ISSUE;
                    cmd_pop    = 1'b1;
                    write_d    = cmd_head[FW-1];
                    addr_d     = cmd_head[FW-2 -: ADDR_W];
                    wdata_d    = cmd_head[DATA_W-1:0];
                    transfer_d = 1'b1;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign addr     = addr_q;
    assign write    = write_q;
    assign wdata    = wdata_q;
    assign transfer = transfer_q;
    assign busy     = (state_q != IDLE) || !cmd_empty;
endmodule

// File: tb/tb_axi4_lite_cmd_sequencer.sv
// Randomized bench for axi4_lite_cmd_sequencer: a latency-randomized master/slave
// model answers transfers while a queue-based reference predicts issues and responses.

module tb_axi4_lite_cmd_sequencer;
    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
    logic [3:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, write, transfer, busy, ready;
    logic [31:0] rsp_rdata, wdata, rdata;
    logic [3:0]  addr;
    logic [2:0]  cmd_count;

    logic        ready_m = 1'b0, ready_x = 1'b0, hold_ready = 1'b0;
    logic [31:0] rdata_m = '0;

    always #5 ACLK = ~ACLK;

    assign ready = ready_m | ready_x;
    assign rdata = ready_x ? 32'hDEAD_BEEF : rdata_m;

    axi4_lite_cmd_sequencer dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .addr(addr), .write(write), .wdata(wdata), .transfer(transfer),
        .ready(ready), .rdata(rdata), .busy(busy), .cmd_count(cmd_count)
    );

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
    } cmd_t;

    int          total = 0, bad = 0, xfer_cnt = 0;
    cmd_t        exp_issue[$];
    logic [31:0] exp_rsp[$];
    logic [31:0] ref_mem[4] = '{default: 32'h0};
    logic [31:0] slave_mem[4] = '{default: 32'h0};
    logic        prev_xfer = 1'b0;
    cmd_t        mon_c;

    // Issue monitor: every pulse must be one cycle and match the next accepted command.
    always @(negedge ACLK) begin
        if (transfer) begin
            xfer_cnt++;
            total++;
            if (exp_issue.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected got addr=%h write=%b", addr, write);
            end else begin
                mon_c = exp_issue.pop_front();
                if (write !== mon_c.w || addr !== mon_c.a || (mon_c.w && wdata !== mon_c.d) || prev_xfer) begin
                    bad++;
                    $display("FAIL issue_order got w=%b a=%h d=%h prev=%b want w=%b a=%h d=%h",
                             write, addr, wdata, prev_xfer, mon_c.w, mon_c.a, mon_c.d);
                end
            end
        end
        prev_xfer = transfer;
    end

    // Master + slave model: answers each transfer after a random delay, honours hold_ready.
    always begin : master_model
        logic [3:0]  ma;
        logic        mw;
        logic [31:0] md;
        int          lat;
        @(negedge ACLK);
        if (transfer) begin
            ma = addr; mw = write; md = wdata;
            lat = $urandom_range(0, 2);
            @(posedge ACLK); #1;
            for (int i = 0; i < lat; i++) begin @(posedge ACLK); #1; end
            while (hold_ready) begin @(posedge ACLK); #1; end
            ready_m = 1'b1;
            rdata_m = mw ? $urandom : slave_mem[ma[3:2]];
            if (mw) slave_mem[ma[3:2]] = md;
            @(posedge ACLK); #1;
            ready_m = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge ACLK); #1; end
    endtask

    task automatic push_cmd(input logic w, input logic [3:0] a, input logic [31:0] d);
        int   t;
        cmd_t c;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        t = 0;
        @(negedge ACLK);
        while (!cmd_ready && t < 300) begin @(negedge ACLK); t++; end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL push_timeout cmd_ready=%b want 1", cmd_ready);
        end else begin
            @(posedge ACLK);
            c = '{w, a, d};
            exp_issue.push_back(c);
            if (w) ref_mem[a[3:2]] = d;
            else   exp_rsp.push_back(ref_mem[a[3:2]]);
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic pop_rsp(input int n);
        int          t;
        logic [31:0] e;
        for (int i = 0; i < n; i++) begin
            rsp_ready = 1'b1;
            t = 0;
            @(negedge ACLK);
            while (!rsp_valid && t < 300) begin @(negedge ACLK); t++; end
            total++;
            if (!rsp_valid) begin
                bad++;
                $display("FAIL rsp_timeout rsp_valid=%b want 1", rsp_valid);
            end else begin
                e = (exp_rsp.size() != 0) ? exp_rsp.pop_front() : 32'hx;
                if (rsp_rdata !== e) begin
                    bad++;
                    $display("FAIL rsp_data got %h want %h", rsp_rdata, e);
                end
            end
            @(posedge ACLK); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        @(negedge ACLK);
        while (busy && t < 500) begin @(negedge ACLK); t++; end
        if (busy) begin
            total++; bad++;
            $display("FAIL drain_timeout busy=%b want 0", busy);
        end
        cyc(3);
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        cyc(3);
        ARESETn = 1'b1;
        @(negedge ACLK);
        total++;
        if ({transfer, write, addr, wdata} !== 38'h0) begin
            bad++; $display("FAIL reset_master_if got t=%b w=%b a=%h d=%h want 0", transfer, write, addr, wdata);
        end
        total++;
        if ({rsp_valid, busy, cmd_count, cmd_ready} !== 6'b000001) begin
            bad++; $display("FAIL reset_status got rv=%b busy=%b cnt=%0d crdy=%b want 0 0 0 1",
                            rsp_valid, busy, cmd_count, cmd_ready);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_writes_then_reads();
        int base = xfer_cnt;
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 4'(i * 4), 32'(i + 1));
        for (int i = 0; i < 4; i++) push_cmd(1'b0, 4'(i * 4), 32'h0);
        drain();
        @(negedge ACLK); #1;
        total++;
        if (xfer_cnt - base != 8) begin
            bad++; $display("FAIL wr_rd_pulses got %0d want 8", xfer_cnt - base);
        end
        @(posedge ACLK); #1;
        pop_rsp(4);
        @(negedge ACLK);
        total++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL wr_rd_idle got busy=%b rv=%b want 0 0", busy, rsp_valid);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_cmd_full();
        int   base = xfer_cnt;
        logic seen_ready = 1'b0;
        logic [3:0]  a6 = 4'($urandom);
        logic [31:0] d6 = $urandom;
        hold_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_cmd(1'b1, 4'($urandom), $urandom);
        cyc(4);
        @(negedge ACLK); #1;
        total++;
        if (cmd_count !== 3'd4 || cmd_ready !== 1'b0 || xfer_cnt - base != 1) begin
            bad++; $display("FAIL full_state got cnt=%0d crdy=%b issued=%0d want 4 0 1",
                            cmd_count, cmd_ready, xfer_cnt - base);
        end
        @(posedge ACLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a6; cmd_wdata = d6;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            if (cmd_ready) seen_ready = 1'b1;
        end
        total++;
        if (seen_ready !== 1'b0) begin
            bad++; $display("FAIL full_refuse got cmd_ready=1 want 0 while held");
        end
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
        hold_ready = 1'b0;
        push_cmd(1'b1, a6, d6);
        drain();
        total++;
        if (xfer_cnt - base != 6 || exp_issue.size() != 0) begin
            bad++; $display("FAIL full_no_loss got issued=%0d pending=%0d want 6 0",
                            xfer_cnt - base, exp_issue.size());
        end
    endtask

    task automatic test_rsp_backpressure();
        int base = xfer_cnt;
        int b2;
        rsp_ready = 1'b0;
        push_cmd(1'b1, 4'h4, 32'h2);
        for (int i = 0; i < 5; i++) push_cmd(1'b0, 4'h4, 32'h0);
        cyc(20);
        @(negedge ACLK); #1;
        total++;
        if (xfer_cnt - base != 5 || cmd_count !== 3'd1 || rsp_valid !== 1'b1) begin
            bad++; $display("FAIL bp_stall got issued=%0d cnt=%0d rv=%b want 5 1 1",
                            xfer_cnt - base, cmd_count, rsp_valid);
        end
        cyc(5);
        @(negedge ACLK); #1;
        total++;
        if (xfer_cnt - base != 5) begin
            bad++; $display("FAIL bp_hold got issued=%0d want 5", xfer_cnt - base);
        end
        @(posedge ACLK); #1;
        pop_rsp(1);
        b2 = xfer_cnt;
        @(negedge ACLK);
        @(negedge ACLK); #1;
        total++;
        if (xfer_cnt - b2 != 1) begin
            bad++; $display("FAIL bp_release got issued=%0d want 1 within 2 cycles", xfer_cnt - b2);
        end
        @(posedge ACLK); #1;
        drain();
        pop_rsp(4);
    endtask

    task automatic test_ready_outside_wait();
        int t = 0;
        ready_x = 1'b1;
        cyc(3);
        ready_x = 1'b0;
        @(negedge ACLK);
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || transfer !== 1'b0) begin
            bad++; $display("FAIL rdy_idle got rv=%b busy=%b t=%b want 0 0 0", rsp_valid, busy, transfer);
        end
        @(posedge ACLK); #1;
        hold_ready = 1'b1;
        push_cmd(1'b0, 4'($urandom), 32'h0);
        @(negedge ACLK);
        while (!transfer && t < 20) begin @(negedge ACLK); t++; end
        ready_x = 1'b1;
        @(posedge ACLK); #1;
        ready_x = 1'b0;
        cyc(3);
        @(negedge ACLK);
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL rdy_issue got rv=%b busy=%b want 0 1", rsp_valid, busy);
        end
        @(posedge ACLK); #1;
        hold_ready = 1'b0;
        pop_rsp(1);
        drain();
    endtask

    task automatic test_reset_mid_wait();
        int t = 0;
        hold_ready = 1'b1;
        push_cmd(1'b0, 4'($urandom), 32'h0);
        @(negedge ACLK);
        while (!transfer && t < 20) begin @(negedge ACLK); t++; end
        @(posedge ACLK); #1;
        cyc(1);
        ARESETn = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        void'(exp_rsp.pop_back());
        @(negedge ACLK);
        total++;
        if ({transfer, write, addr, wdata, rsp_valid, busy, cmd_count, cmd_ready} !== {38'h0, 6'b000001}) begin
            bad++; $display("FAIL rst_wait_state got t=%b w=%b a=%h d=%h rv=%b busy=%b cnt=%0d crdy=%b want zeros crdy=1",
                            transfer, write, addr, wdata, rsp_valid, busy, cmd_count, cmd_ready);
        end
        @(posedge ACLK); #1;
        hold_ready = 1'b0;
        cyc(6);
        @(negedge ACLK);
        total++;
        if (rsp_valid !== 1'b0 || cmd_count !== 3'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_late_ready got rv=%b cnt=%0d busy=%b want 0 0 0", rsp_valid, cmd_count, busy);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_push_pop();
        int   t = 0;
        cmd_t c;
        logic [3:0]  ad = 4'($urandom);
        logic [31:0] dd = $urandom;
        logic        wd = 1'($urandom);
        hold_ready = 1'b1;
        push_cmd(1'($urandom), 4'($urandom), $urandom);
        push_cmd(1'($urandom), 4'($urandom), $urandom);
        push_cmd(1'($urandom), 4'($urandom), $urandom);
        cyc(2);
        @(negedge ACLK);
        total++;
        if (cmd_count !== 3'd2) begin
            bad++; $display("FAIL pp_setup got cnt=%0d want 2", cmd_count);
        end
        @(posedge ACLK); #1;
        hold_ready = 1'b0;
        @(negedge ACLK);
        while (!ready_m && t < 20) begin @(negedge ACLK); t++; end
        @(posedge ACLK); #1;
        cmd_valid = 1'b1; cmd_write = wd; cmd_addr = ad; cmd_wdata = dd;
        @(posedge ACLK);
        c = '{wd, ad, dd};
        exp_issue.push_back(c);
        if (wd) ref_mem[ad[3:2]] = dd;
        else    exp_rsp.push_back(ref_mem[ad[3:2]]);
        #1 cmd_valid = 1'b0;
        @(negedge ACLK);
        total++;
        if (cmd_count !== 3'd2 || transfer !== 1'b1) begin
            bad++; $display("FAIL pp_count got cnt=%0d t=%b want 2 1", cmd_count, transfer);
        end
        @(posedge ACLK); #1;
        drain();
        pop_rsp(exp_rsp.size());
    endtask

    task automatic test_random();
        cmd_t cl[$];
        int   nreads = 0;
        for (int i = 0; i < 40; i++) begin
            cmd_t c;
            c = '{1'($urandom), 4'($urandom), $urandom};
            if (!c.w) nreads++;
            cl.push_back(c);
        end
        fork
            begin
                foreach (cl[i]) begin
                    push_cmd(cl[i].w, cl[i].a, cl[i].d);
                    cyc($urandom_range(0, 2));
                end
            end
            begin
                int          got = 0, t = 0;
                logic [31:0] e;
                while (got < nreads && t < 3000) begin
                    rsp_ready = 1'($urandom);
                    @(negedge ACLK);
                    if (rsp_valid && rsp_ready) begin
                        e = (exp_rsp.size() != 0) ? exp_rsp.pop_front() : 32'hx;
                        total++;
                        if (rsp_rdata !== e) begin
                            bad++; $display("FAIL rand_rsp got %h want %h", rsp_rdata, e);
                        end
                        got++;
                    end
                    @(posedge ACLK); #1;
                    t++;
                end
                rsp_ready = 1'b0;
                if (got < nreads) begin
                    total++; bad++;
                    $display("FAIL rand_rsp_timeout got %0d want %0d", got, nreads);
                end
            end
        join
        drain();
        @(negedge ACLK);
        total++;
        if (exp_issue.size() != 0 || exp_rsp.size() != 0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rand_final got pend_issue=%0d pend_rsp=%0d rv=%b want 0 0 0",
                            exp_issue.size(), exp_rsp.size(), rsp_valid);
        end
        @(posedge ACLK); #1;
    endtask

    initial begin
        test_reset();
        test_writes_then_reads();
        test_cmd_full();
        test_rsp_backpressure();
        test_ready_outside_wait();
        test_reset_mid_wait();
        test_push_pop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached want finish earlier");
        $fatal(1);
    end
endmodule
